// File: rtl/clk_divider_sequencer.sv
// -----------------------------------------------------------------------------
// clk_divider_sequencer
//
// Command-driven controller for the ClkDivider block. Host commands (STEP, RUN,
// STOP, SET_DIV, CLR_CNT) are turned into the divider's configuration and
// control inputs. A local phase counter mirrors the divider's internal
// clk_counter so that auto-mode runs can be halted on a period boundary
// without a runt pulse on clk_o. A free-running counter tallies the core clock
// cycles delivered to the processor under test.
//
// Ports
//   clk             system clock, shared with ClkDivider
//   rst             asynchronous, active-high reset
//   cmd_valid       command present on cmd_op/cmd_data
//   cmd_ready       command accepted on a cycle with cmd_valid && cmd_ready
//   cmd_op          0 NOP, 1 SET_DIV, 2 STEP, 3 RUN, 4 STOP, 5 CLR_CNT
//   cmd_data        operand: divider for SET_DIV, cycle count N for STEP
//   div_write_pulse to ClkDivider.write_pulse (one-cycle strobe)
//   div_option      to ClkDivider.option (0 pulse mode, 1 auto mode)
//   div_out_enable  to ClkDivider.out_enable
//   div_divider     to ClkDivider.divider
//   div_pulse       to ClkDivider.pulse
//   busy            controller is not idle
//   done            one-cycle pulse: STEP finished or STOP completed
//   cmd_err         one-cycle pulse: illegal op or SET_DIV operand below 2
//   cycle_count     core clock cycles delivered since reset or CLR_CNT
// -----------------------------------------------------------------------------
module clk_divider_sequencer #(
  parameter int COUNTER_BITS       = 32,
  parameter int PULSE_CONTROL_BITS = 32,
  parameter int DATA_BITS          = 32,
  parameter int CYCLE_COUNT_BITS   = 64,
  parameter int DEFAULT_DIVIDER    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [2:0]                    cmd_op,
  input  logic [DATA_BITS-1:0]          cmd_data,
  output logic                          div_write_pulse,
  output logic                          div_option,
  output logic                          div_out_enable,
  output logic [COUNTER_BITS-1:0]       div_divider,
  output logic [PULSE_CONTROL_BITS-1:0] div_pulse,
  output logic                          busy,
  output logic                          done,
  output logic                          cmd_err,
  output logic [CYCLE_COUNT_BITS-1:0]   cycle_count
);

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_SET_DIV = 3'd1;
  localparam logic [2:0] OP_STEP    = 3'd2;
  localparam logic [2:0] OP_RUN     = 3'd3;
  localparam logic [2:0] OP_STOP    = 3'd4;
  localparam logic [2:0] OP_CLR_CNT = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STEP_LOAD,
    ST_STEPPING,
    ST_RUNNING,
    ST_HALTING
  } state_t;

  state_t                          state_q, state_d;
  logic [COUNTER_BITS-1:0]         phase_q, phase_d;
  logic [PULSE_CONTROL_BITS-1:0]   remaining_q, remaining_d;
  logic [CYCLE_COUNT_BITS-1:0]     count_d;
  logic                            write_pulse_d;
  logic                            option_d;
  logic                            out_enable_d;
  logic [COUNTER_BITS-1:0]         divider_d;
  logic [PULSE_CONTROL_BITS-1:0]   pulse_d;
  logic                            done_d;
  logic                            err_d;

  logic                            phase_wrap;
  logic                            stop_req;
  logic                            set_div_ok;
  logic [COUNTER_BITS-1:0]         cmd_divider;
  logic [PULSE_CONTROL_BITS-1:0]   step_n;
  logic [CYCLE_COUNT_BITS-1:0]     count_inc;

  // Same wrap rule as ClkDivider's clk_counter; the auto clock rises on phase 0.
  assign phase_wrap  = (phase_q >= div_divider - COUNTER_BITS'(1));
  assign stop_req    = cmd_valid && (cmd_op == OP_STOP);
  assign cmd_divider = cmd_data[COUNTER_BITS-1:0];
  assign step_n      = cmd_data[PULSE_CONTROL_BITS-1:0];
  assign count_inc   = cycle_count + CYCLE_COUNT_BITS'(1);
  // Judge the value actually loaded, so a truncated operand can never
  // program a divider below 2.
  assign set_div_ok  = (cmd_divider >= COUNTER_BITS'(2));

  assign busy = (state_q != ST_IDLE);

  // Ready depends on the presented op while stepping/running: only STOP may
  // interrupt, everything else is back-pressured until IDLE.
  always_comb begin
    cmd_ready = 1'b0;
    unique case (state_q)
      ST_IDLE:                  cmd_ready = 1'b1;
      ST_STEPPING, ST_RUNNING:  cmd_ready = (cmd_op == OP_STOP);
      default:                  cmd_ready = 1'b0;
    endcase
  end

  // NOTE: every variable gets a default before any branch so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    phase_d       = phase_wrap ? '0 : phase_q + COUNTER_BITS'(1);
    remaining_d   = remaining_q;
    count_d       = cycle_count;
    write_pulse_d = 1'b0;
    option_d      = div_option;
    out_enable_d  = div_out_enable;
    divider_d     = div_divider;
    pulse_d       = div_pulse;
    done_d        = 1'b0;
    err_d         = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_NOP, OP_STOP: begin
              // Nothing to do while idle.
            end
            OP_SET_DIV: begin
              if (set_div_ok) divider_d = cmd_divider;
              else            err_d     = 1'b1;
            end
            OP_STEP: begin
              if (step_n == '0) begin
                done_d = 1'b1;
              end else begin
                pulse_d       = step_n;
                option_d      = 1'b0;
                write_pulse_d = 1'b1;
                out_enable_d  = 1'b1;
                remaining_d   = step_n;
                state_d       = ST_STEP_LOAD;
              end
            end
            OP_RUN: begin
              option_d     = 1'b1;
              out_enable_d = 1'b1;
              state_d      = ST_RUNNING;
            end
            OP_CLR_CNT: begin
              count_d = '0;
            end
            default: begin
              err_d = 1'b1;
            end
          endcase
        end
      end

      // The divider samples div_pulse on the write strobe; give it one cycle.
      ST_STEP_LOAD: begin
        state_d = ST_STEPPING;
      end

      ST_STEPPING: begin
        count_d     = count_inc;
        remaining_d = remaining_q - PULSE_CONTROL_BITS'(1);
        if (stop_req) begin
          // Rewriting a zero pulse count cancels the divider's pending cycles.
          pulse_d       = '0;
          write_pulse_d = 1'b1;
          out_enable_d  = 1'b0;
          done_d        = 1'b1;
          state_d       = ST_IDLE;
        end else if (remaining_q == PULSE_CONTROL_BITS'(1)) begin
          out_enable_d = 1'b0;
          done_d       = 1'b1;
          state_d      = ST_IDLE;
        end
      end

      ST_RUNNING: begin
        if (div_out_enable && phase_q == '0) count_d = count_inc;
        if (stop_req) state_d = ST_HALTING;
      end

      // Keep the clock enabled until the last high/low period has completed;
      // gating at the wrap point means the next rising edge never appears.
      ST_HALTING: begin
        if (div_out_enable && phase_q == '0) count_d = count_inc;
        if (phase_wrap) begin
          out_enable_d = 1'b0;
          option_d     = 1'b0;
          done_d       = 1'b1;
          state_d      = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      phase_q         <= '0;
      remaining_q     <= '0;
      cycle_count     <= '0;
      div_write_pulse <= 1'b0;
      div_option      <= 1'b0;
      div_out_enable  <= 1'b0;
      div_divider     <= COUNTER_BITS'(DEFAULT_DIVIDER);
      div_pulse       <= '0;
      done            <= 1'b0;
      cmd_err         <= 1'b0;
    end else begin
      state_q         <= state_d;
      phase_q         <= phase_d;
      remaining_q     <= remaining_d;
      cycle_count     <= count_d;
      div_write_pulse <= write_pulse_d;
      div_option      <= option_d;
      div_out_enable  <= out_enable_d;
      div_divider     <= divider_d;
      div_pulse       <= pulse_d;
      done            <= done_d;
      cmd_err         <= err_d;
    end
  end

endmodule

// File: tb/tb_clk_divider_sequencer.sv
// -----------------------------------------------------------------------------
// tb_clk_divider_sequencer
//
// Self-checking bench for clk_divider_sequencer. Expected done / cmd_err
// events are queued as commands are issued and matched when the DUT pulses.
// An independent phase counter models ClkDivider's clk_counter so that the
// point where out_enable drops after a RUN/STOP can be checked against a
// period boundary.
// -----------------------------------------------------------------------------
module tb_clk_divider_sequencer;

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_SET_DIV = 3'd1;
  localparam logic [2:0] OP_STEP    = 3'd2;
  localparam logic [2:0] OP_RUN     = 3'd3;
  localparam logic [2:0] OP_STOP    = 3'd4;
  localparam logic [2:0] OP_CLR_CNT = 3'd5;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_data;
  logic        div_write_pulse;
  logic        div_option;
  logic        div_out_enable;
  logic [31:0] div_divider;
  logic [31:0] div_pulse;
  logic        busy;
  logic        done;
  logic        cmd_err;
  logic [63:0] cycle_count;

  clk_divider_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_op          (cmd_op),
    .cmd_data        (cmd_data),
    .div_write_pulse (div_write_pulse),
    .div_option      (div_option),
    .div_out_enable  (div_out_enable),
    .div_divider     (div_divider),
    .div_pulse       (div_pulse),
    .busy            (busy),
    .done            (done),
    .cmd_err         (cmd_err),
    .cycle_count     (cycle_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Scoreboard of expected done / cmd_err pulses.
  typedef struct {
    logic        is_err;
    logic        chk_cnt;
    logic [63:0] lo;
    logic [63:0] hi;
  } sb_t;

  sb_t sb_q[$];

  task automatic sb_push(input logic is_err, input logic chk_cnt,
                         input logic [63:0] lo, input logic [63:0] hi);
    sb_t e;
    e.is_err  = is_err;
    e.chk_cnt = chk_cnt;
    e.lo      = lo;
    e.hi      = hi;
    sb_q.push_back(e);
  endtask

  // Reference phase: ClkDivider's clk_counter, driven by the bench's own
  // record of the programmed divider.
  logic [31:0] exp_div;
  logic [31:0] tb_phase;

  always @(posedge clk or posedge rst) begin
    if (rst)                          tb_phase <= '0;
    else if (tb_phase >= exp_div - 1) tb_phase <= '0;
    else                              tb_phase <= tb_phase + 1;
  end

  int          wp_count = 0;
  logic [31:0] last_wp_pulse = '0;
  logic        expect_halt;
  logic        prev_oe = 1'b0;

  always @(negedge clk) begin : monitor
    sb_t e;
    if (!rst) begin
      if (div_write_pulse) begin
        wp_count++;
        last_wp_pulse = div_pulse;
      end
      if (done || cmd_err) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_event", {62'd0, done, cmd_err}, 64'd0);
        end else begin
          e = sb_q.pop_front();
          check(e.is_err ? "sb_err_kind" : "sb_done_kind",
                {62'd0, done, cmd_err}, e.is_err ? 64'd1 : 64'd2);
          if (e.chk_cnt)
            check("sb_count_range",
                  64'(cycle_count >= e.lo && cycle_count <= e.hi), 64'd1);
        end
      end
      if (expect_halt && prev_oe && !div_out_enable) begin
        check("halt_phase_boundary", 64'(tb_phase), 64'd0);
        check("halt_option_cleared", 64'(div_option), 64'd0);
      end
    end
    prev_oe = div_out_enable;
  end

  task automatic send_cmd(input logic [2:0] op, input logic [31:0] data);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    #1;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!cmd_ready) check("send_cmd_ready_timeout", 64'(cmd_ready), 64'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
    cmd_data  = '0;
  endtask

  task automatic wait_drained(input string tag, input int max_cycles);
    int n = 0;
    while ((sb_q.size() != 0 || busy) && n < max_cycles) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(tag, 64'(sb_q.size() == 0 && !busy), 64'd1);
  endtask

  task automatic check_reset(input string p);
    check({p, "_divider"},     64'(div_divider),     64'd2);
    check({p, "_cmd_ready"},   64'(cmd_ready),       64'd1);
    check({p, "_busy"},        64'(busy),            64'd0);
    check({p, "_out_enable"},  64'(div_out_enable),  64'd0);
    check({p, "_option"},      64'(div_option),      64'd0);
    check({p, "_write_pulse"}, 64'(div_write_pulse), 64'd0);
    check({p, "_pulse"},       64'(div_pulse),       64'd0);
    check({p, "_done"},        64'(done),            64'd0);
    check({p, "_cmd_err"},     64'(cmd_err),         64'd0);
    check({p, "_cycle_count"}, cycle_count,          64'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog_timeout got=%0d exp=%0d", checks, 0);
    $fatal(1, "bench timed out");
  end

  initial begin : stimulus
    int wp_base;
    int wait_cycles;
    int oe_hits;

    rst         = 1'b1;
    cmd_valid   = 1'b0;
    cmd_op      = OP_NOP;
    cmd_data    = '0;
    exp_div     = 32'd2;
    expect_halt = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset("reset");

    // Illegal SET_DIV operand and illegal opcode: error pulses only.
    sb_push(1'b1, 1'b0, 64'd0, 64'd0);
    send_cmd(OP_SET_DIV, 32'd1);
    sb_push(1'b1, 1'b0, 64'd0, 64'd0);
    send_cmd(3'd7, 32'd0);
    wait_drained("err_drain", 20);
    check("err_divider_kept", 64'(div_divider), 64'd2);
    check("err_cmd_ready",    64'(cmd_ready),   64'd1);

    // STOP and NOP while idle: no pulse of any kind.
    send_cmd(OP_STOP, 32'd0);
    send_cmd(OP_NOP, 32'd0);
    repeat (3) @(negedge clk);
    check("idle_stop_no_busy", 64'(busy), 64'd0);

    // STEP 5 from a zero count.
    wp_base = wp_count;
    sb_push(1'b0, 1'b1, 64'd5, 64'd5);
    send_cmd(OP_STEP, 32'd5);
    check("step_load_busy",      64'(busy),      64'd1);
    check("step_load_not_ready", 64'(cmd_ready), 64'd0);
    check("step_option_pulse",   64'(div_option), 64'd0);
    wait_drained("step5_drain", 50);
    check("step5_write_pulses", 64'(wp_count - wp_base), 64'd1);
    check("step5_pulse_value",  64'(last_wp_pulse),      64'd5);
    check("step5_oe_off",       64'(div_out_enable),     64'd0);
    check("step5_count",        cycle_count,             64'd5);

    // STEP 0: done next cycle, no divider write, count untouched.
    wp_base = wp_count;
    sb_push(1'b0, 1'b1, 64'd5, 64'd5);
    send_cmd(OP_STEP, 32'd0);
    wait_drained("step0_drain", 20);
    check("step0_no_write", 64'(wp_count - wp_base), 64'd0);

    // SET_DIV 4, RUN for 40 cycles: one delivered cycle per 4 clocks.
    send_cmd(OP_CLR_CNT, 32'd0);
    check("clr_count", cycle_count, 64'd0);
    send_cmd(OP_SET_DIV, 32'd4);
    exp_div = 32'd4;
    check("setdiv4_divider", 64'(div_divider), 64'd4);
    send_cmd(OP_RUN, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    check("run4_count_range", 64'(cycle_count >= 64'd9 && cycle_count <= 64'd11), 64'd1);
    check("run4_option",      64'(div_option),     64'd1);
    check("run4_out_enable",  64'(div_out_enable), 64'd1);
    check("run4_not_ready",   64'(cmd_ready),      64'd0);
    expect_halt = 1'b1;
    sb_push(1'b0, 1'b0, 64'd0, 64'd0);
    send_cmd(OP_STOP, 32'd0);
    wait_drained("run4_stop_drain", 20);
    expect_halt = 1'b0;

    // RUN at divider 6, STOP at an arbitrary phase.
    send_cmd(OP_SET_DIV, 32'd6);
    exp_div = 32'd6;
    send_cmd(OP_RUN, 32'd0);
    wait_cycles = $urandom_range(3, 20);
    repeat (wait_cycles) @(posedge clk);
    expect_halt = 1'b1;
    sb_push(1'b0, 1'b0, 64'd0, 64'd0);
    send_cmd(OP_STOP, 32'd0);
    wait_drained("run6_stop_drain", 20);
    expect_halt = 1'b0;
    check("run6_busy_clear", 64'(busy),           64'd0);
    check("run6_oe_off",     64'(div_out_enable), 64'd0);

    // STEP 100 interrupted after 10 stepping cycles.
    send_cmd(OP_CLR_CNT, 32'd0);
    wp_base = wp_count;
    sb_push(1'b0, 1'b1, 64'd9, 64'd11);
    send_cmd(OP_STEP, 32'd100);
    repeat (10) @(posedge clk);
    send_cmd(OP_STOP, 32'd0);
    wait_drained("step_stop_drain", 20);
    check("step_stop_write_pulses", 64'(wp_count - wp_base), 64'd2);
    check("step_stop_pulse_zero",   64'(last_wp_pulse),      64'd0);
    check("step_stop_oe_off",       64'(div_out_enable),     64'd0);

    // Asynchronous reset in the middle of a run.
    send_cmd(OP_SET_DIV, 32'd3);
    exp_div = 32'd3;
    send_cmd(OP_RUN, 32'd0);
    repeat (7) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    exp_div = 32'd2;
    check_reset("rst_async");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    oe_hits = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1;
      if (div_out_enable) oe_hits++;
    end
    check("post_rst_no_clock", 64'(oe_hits),   64'd0);
    check("post_rst_count",    cycle_count,    64'd0);
    check("post_rst_idle",     64'(busy),      64'd0);

    check("sb_empty_at_end", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
